// File: rtl/oled_i2c_target_if.sv
// Parallel byte/strobe side of the OLED I2C target: decoded command/data bytes
// plus frame status, driven by the target (master) and observed by a consumer (slave).
interface oled_i2c_target_if;
  logic [7:0]  oByte;
  logic        oByteValid;
  logic        oIsData;
  logic [15:0] oByteCnt;
  logic        oBusy;
  logic        oFrameEnd;
  logic        oNack;

  modport master (
    output oByte, oByteValid, oIsData, oByteCnt, oBusy, oFrameEnd, oNack
  );

  modport slave (
    input oByte, oByteValid, oIsData, oByteCnt, oBusy, oFrameEnd, oNack
  );
endinterface

// File: rtl/oled_i2c_target.sv
// Write-only I2C target that decodes SSD1306-style control bytes (Co, D/C#) and
// presents every command/data byte as a one-clock strobe on the byte interface.
module oled_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h3C,
  parameter int         FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  inout  wire  ioScl,
  inout  wire  ioSda,
  oled_i2c_target_if.master bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_ACK    = 3'd2;
  localparam logic [2:0] ST_CTRL   = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0] raw;
  logic [1:0] filt;
  logic [1:0] rise;
  logic [1:0] fall;

  assign raw = {ioSda, ioScl};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic       sync1_reg;
      logic       sync2_reg;
      logic       filt_reg;
      logic       rise_reg;
      logic       fall_reg;
      logic [3:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          cnt_reg   <= 4'd0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          if (sync2_reg == filt_reg) begin
            cnt_reg <= 4'd0;
          end else if (cnt_reg == FILT_LAST) begin
            // New level has been stable for FILT_LEN samples: accept it.
            filt_reg <= sync2_reg;
            rise_reg <= sync2_reg;
            fall_reg <= ~sync2_reg;
            cnt_reg  <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
      end

      assign filt[gi] = filt_reg;
      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;
    end
  endgenerate

  logic scl_rise;
  logic scl_fall;
  logic scl_high;
  logic start_cond;
  logic stop_cond;

  assign scl_rise = rise[0];
  assign scl_fall = fall[0];
  // SCL counts as high if it is high now or was high until this very clock,
  // so an SDA edge coinciding with an SCL edge is still a START/STOP.
  assign scl_high   = filt[0] | fall[0];
  assign start_cond = fall[1] & scl_high;
  assign stop_cond  = rise[1] & scl_high;

  logic [2:0]  state_reg;
  logic [2:0]  pend_reg;
  logic [2:0]  bit_cnt_reg;
  logic [6:0]  shift_reg;
  logic        co_reg;
  logic        dc_reg;
  logic        sda_oe_reg;
  logic        ack_hold_reg;
  logic [7:0]  byte_reg;
  logic        byte_valid_reg;
  logic        is_data_reg;
  logic [15:0] byte_cnt_reg;
  logic        busy_reg;
  logic        frame_end_reg;
  logic        nack_reg;
  logic [7:0]  rx_byte;

  assign rx_byte = {shift_reg, filt[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      pend_reg       <= ST_IDLE;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 7'd0;
      co_reg         <= 1'b0;
      dc_reg         <= 1'b0;
      sda_oe_reg     <= 1'b0;
      ack_hold_reg   <= 1'b0;
      byte_reg       <= 8'd0;
      byte_valid_reg <= 1'b0;
      is_data_reg    <= 1'b0;
      byte_cnt_reg   <= 16'd0;
      busy_reg       <= 1'b0;
      frame_end_reg  <= 1'b0;
      nack_reg       <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      frame_end_reg  <= 1'b0;
      nack_reg       <= 1'b0;
      if (start_cond) begin
        state_reg    <= ST_ADDR;
        bit_cnt_reg  <= 3'd0;
        byte_cnt_reg <= 16'd0;
        busy_reg     <= 1'b1;
        sda_oe_reg   <= 1'b0;
        ack_hold_reg <= 1'b0;
      end else if (stop_cond) begin
        state_reg     <= ST_IDLE;
        bit_cnt_reg   <= 3'd0;
        busy_reg      <= 1'b0;
        sda_oe_reg    <= 1'b0;
        ack_hold_reg  <= 1'b0;
        frame_end_reg <= (byte_cnt_reg != 16'd0);
      end else begin
        case (state_reg)
          ST_ADDR, ST_CTRL, ST_DATA: begin
            if (scl_rise) begin
              shift_reg <= rx_byte[6:0];
              if (bit_cnt_reg == 3'd7) begin
                bit_cnt_reg <= 3'd0;
                case (state_reg)
                  ST_ADDR: begin
                    if (rx_byte[7:1] == I2C_ADDR && !rx_byte[0]) begin
                      state_reg <= ST_ACK;
                      pend_reg  <= ST_CTRL;
                    end else begin
                      nack_reg  <= 1'b1;
                      state_reg <= ST_IGNORE;
                    end
                  end
                  ST_CTRL: begin
                    co_reg    <= rx_byte[7];
                    dc_reg    <= rx_byte[6];
                    state_reg <= ST_ACK;
                    pend_reg  <= ST_DATA;
                  end
                  default: begin
                    byte_reg       <= rx_byte;
                    is_data_reg    <= dc_reg;
                    byte_valid_reg <= 1'b1;
                    if (byte_cnt_reg != 16'hFFFF)
                      byte_cnt_reg <= byte_cnt_reg + 16'd1;
                    state_reg <= ST_ACK;
                    pend_reg  <= co_reg ? ST_CTRL : ST_DATA;
                  end
                endcase
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
              end
            end
          end
          ST_ACK: begin
            // First SCL fall opens the ACK bit, the second one closes it.
            if (scl_fall) begin
              if (!ack_hold_reg) begin
                sda_oe_reg   <= 1'b1;
                ack_hold_reg <= 1'b1;
              end else begin
                sda_oe_reg   <= 1'b0;
                ack_hold_reg <= 1'b0;
                state_reg    <= pend_reg;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ioSda = sda_oe_reg ? 1'b0 : 1'bz;

  assign bus.oByte      = byte_reg;
  assign bus.oByteValid = byte_valid_reg;
  assign bus.oIsData    = is_data_reg;
  assign bus.oByteCnt   = byte_cnt_reg;
  assign bus.oBusy      = busy_reg;
  assign bus.oFrameEnd  = frame_end_reg;
  assign bus.oNack      = nack_reg;

endmodule

// File: tb/tb_oled_i2c_target.sv
// Directed bench for oled_i2c_target: an I2C master model drives table-driven
// bus operations, and strobe/pulse monitors are compared against hand-computed values.
module tb_oled_i2c_target;

  localparam int Q = 16;

  localparam int OP_START = 0;
  localparam int OP_BYTE  = 1;
  localparam int OP_STOP  = 2;
  localparam int OP_BITS4 = 3;

  typedef struct {
    int         op;
    logic [7:0] data;
    int         ack;
    int         nstb;
    logic [7:0] sbyte;
    int         sdata;
    int         cnt;
    int         busy;
    int         fend;
    int         nack;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  scl_bus;
  wire  sda_bus;

  assign scl_bus = m_scl;
  assign sda_bus = m_sda ? 1'bz : 1'b0;
  pullup (sda_bus);

  oled_i2c_target_if bus ();

  oled_i2c_target #(.I2C_ADDR(7'h3C), .FILT_LEN(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .ioScl (scl_bus),
    .ioSda (sda_bus),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         stb_n = 0;
  int         stb_wide = 0;
  int         fend_n = 0;
  int         nack_n = 0;
  int         dut_low = 0;
  logic [7:0] last_byte = 8'h00;
  int         last_isdata = 0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.oByteValid) begin
      stb_n++;
      last_byte   = bus.oByte;
      last_isdata = int'(bus.oIsData);
      if (prev_valid) stb_wide++;
    end
    prev_valid = bus.oByteValid;
    if (bus.oFrameEnd) fend_n++;
    if (bus.oNack) nack_n++;
    if (m_sda && sda_bus == 1'b0) dut_low++;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(2 * Q);
      m_scl = 1'b0; tick(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int ack);
    send_bits(b, 8);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    ack = (sda_bus == 1'b0) ? 1 : 0;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  function automatic vec_t mk(input int op, input logic [7:0] data, input int ack,
                              input int nstb, input logic [7:0] sbyte, input int sdata,
                              input int cnt, input int busy, input int fend, input int nack);
    vec_t v;
    v.op = op; v.data = data; v.ack = ack; v.nstb = nstb; v.sbyte = sbyte;
    v.sdata = sdata; v.cnt = cnt; v.busy = busy; v.fend = fend; v.nack = nack;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int ack;
    int s0, f0, n0, d0;
    int w;

    // op, data, ack, nstb, sbyte, sdata, cnt, busy, fend, nack
    // Data frame: 0x78, ctrl 0x40, A5, 5A
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h78, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h40, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'hA5, 1, 1, 8'hA5, 1, 1, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h5A, 1, 1, 8'h5A, 1, 2, 1, 0, 0));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 2, 0, 1, 0));
    // Commands with Co toggling
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h78, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h80, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'hAE, 1, 1, 8'hAE, 0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h00, 1, 0, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'hAF, 1, 1, 8'hAF, 0, 2, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'hB0, 1, 1, 8'hB0, 0, 3, 1, 0, 0));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 3, 0, 1, 0));
    // Wrong address, then read address
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h7A, 0, 0, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h79, 0, 0, 8'h00, 0, 0, 1, 0, 1));
    vecs.push_back(mk(OP_BYTE,  8'h40, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
    // Repeated START
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h78, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h40, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h11, 1, 1, 8'h11, 1, 1, 1, 0, 0));
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h78, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h22, 1, 1, 8'h22, 0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 0));
    // STOP after a partial byte, with and without earlier bytes
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h78, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h40, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h33, 1, 1, 8'h33, 1, 1, 1, 0, 0));
    vecs.push_back(mk(OP_BITS4, 8'hF0, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 0));
    vecs.push_back(mk(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h78, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BYTE,  8'h40, 1, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_BITS4, 8'hF0, 0, 0, 8'h00, 0, 0, 1, 0, 0));
    vecs.push_back(mk(OP_STOP,  8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));

    tick(4);
    check("rst_byte",     int'(bus.oByte), 0);
    check("rst_valid",    int'(bus.oByteValid), 0);
    check("rst_isdata",   int'(bus.oIsData), 0);
    check("rst_cnt",      int'(bus.oByteCnt), 0);
    check("rst_busy",     int'(bus.oBusy), 0);
    check("rst_frameend", int'(bus.oFrameEnd), 0);
    check("rst_nack",     int'(bus.oNack), 0);
    check("rst_sda",      int'(sda_bus), 1);
    rst = 1'b0;
    tick(2 * Q);

    foreach (vecs[i]) begin
      s0 = stb_n; f0 = fend_n; n0 = nack_n;
      ack = 0;
      case (vecs[i].op)
        OP_START: do_start();
        OP_BYTE:  send_byte(vecs[i].data, ack);
        OP_STOP:  do_stop();
        default:  send_bits(vecs[i].data, 4);
      endcase
      if (vecs[i].op == OP_BYTE)
        check($sformatf("v%0d_ack", i), ack, vecs[i].ack);
      check($sformatf("v%0d_strobes", i), stb_n - s0, vecs[i].nstb);
      if (vecs[i].nstb > 0) begin
        check($sformatf("v%0d_byte", i), int'(last_byte), int'(vecs[i].sbyte));
        check($sformatf("v%0d_isdata", i), last_isdata, vecs[i].sdata);
        check($sformatf("v%0d_holdbyte", i), int'(bus.oByte), int'(vecs[i].sbyte));
      end
      check($sformatf("v%0d_cnt", i), int'(bus.oByteCnt), vecs[i].cnt);
      check($sformatf("v%0d_busy", i), int'(bus.oBusy), vecs[i].busy);
      check($sformatf("v%0d_frameend", i), fend_n - f0, vecs[i].fend);
      check($sformatf("v%0d_nack", i), nack_n - n0, vecs[i].nack);
      $display("vec %0d op=%0d data=%02h ack=%0d strobes=%0d cnt=%0d busy=%0d",
               i, vecs[i].op, vecs[i].data, ack, stb_n - s0, bus.oByteCnt, bus.oBusy);
    end
    check("strobe_width", stb_wide, 0);

    // Rejected address never drives SDA at any point.
    d0 = dut_low;
    do_start();
    send_byte(8'h7A, ack);
    do_stop();
    check("nack_sda_never_low", dut_low - d0, 0);
    $display("seq nack_sda: dut_low_clks=%0d", dut_low - d0);

    // 2-clk SDA low glitch with SCL high on an idle bus: no START.
    tick(Q);
    m_sda = 1'b0; tick(2);
    m_sda = 1'b1; tick(2 * Q);
    check("glitch_idle_busy", int'(bus.oBusy), 0);
    $display("seq glitch_idle: busy=%0d", bus.oBusy);

    // 2-clk SDA high glitch with SCL high mid-frame: no STOP.
    f0 = fend_n;
    do_start();
    send_byte(8'h78, ack);
    send_byte(8'h40, ack);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2);
    m_sda = 1'b0; tick(2 * Q);
    check("glitch_busy_busy", int'(bus.oBusy), 1);
    $display("seq glitch_busy: busy=%0d", bus.oBusy);
    m_scl = 1'b0; tick(Q);
    do_stop();
    check("glitch_stop_busy", int'(bus.oBusy), 0);
    check("glitch_stop_frameend", fend_n - f0, 0);

    // Reset asserted while the target holds SDA low for an ACK.
    do_start();
    send_byte(8'h78, ack);
    send_byte(8'h40, ack);
    send_byte(8'hA5, ack);
    send_bits(8'h5A, 8);
    m_sda = 1'b1;
    w = 0;
    while (sda_bus != 1'b0 && w < 100) begin
      tick(1);
      w++;
    end
    check("ack_before_rst_sda", int'(sda_bus), 0);
    check("ack_before_rst_cnt", int'(bus.oByteCnt), 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_ack_sda",    int'(sda_bus), 1);
    check("rst_mid_ack_byte",   int'(bus.oByte), 0);
    check("rst_mid_ack_isdata", int'(bus.oIsData), 0);
    check("rst_mid_ack_cnt",    int'(bus.oByteCnt), 0);
    check("rst_mid_ack_busy",   int'(bus.oBusy), 0);
    $display("seq rst_mid_ack: sda=%0d cnt=%0d busy=%0d", sda_bus, bus.oByteCnt, bus.oBusy);
    tick(3);
    rst = 1'b0;
    m_scl = 1'b1;
    tick(2 * Q);
    check("after_rst_busy", int'(bus.oBusy), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
